// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the MEM stage and data memory.
// Stores are queued in an in-order circular FIFO and drained to DM one per
// cycle when DM_Ready is high and no load needs the shared DM address port.
// A load whose word address matches any pending store stalls MEM until
// that store (and everything older) has drained.
//
// Ports:
//   Clock, Reset            rising-edge clock, async active-low reset
//   MemWrite, MemRead       MEM stage store / load requests (mutually exclusive)
//   StoreType, Addr, WD, WPC store attributes from MEM
//   DM_Ready                DM accepts a write this cycle
//   Stall                   hold MEM stage (combinational)
//   DM_*                    DM request: load address/strobe or head-entry write
//   Empty, Full             registered occupancy decodes
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  StoreType,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic [31:0] WPC,
  input  logic        DM_Ready,
  output logic        Stall,
  output logic        DM_MemWrite,
  output logic        DM_MemRead,
  output logic [1:0]  DM_StoreType,
  output logic [31:0] DM_Addr,
  output logic [31:0] DM_WD,
  output logic [31:0] DM_WPC,
  output logic        Empty,
  output logic        Full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [1:0]    st_q   [DEPTH];
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   wd_q   [DEPTH];
  logic [31:0]   wpc_q  [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] off [DEPTH];
  logic          hit;
  logic          push;
  logic          pop;
  logic          load_go;

  assign Empty = (count_q == '0);
  assign Full  = (count_q == CW'(DEPTH));

  // An entry is valid when its distance from head is below count; the
  // pointer subtraction wraps naturally at AW bits.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off[i] = AW'(i) - head_q;
      if (({1'b0, off[i]} < count_q) && (addr_q[i][31:2] == Addr[31:2]))
        hit = MemRead;
    end
  end

  assign load_go = MemRead && !hit;
  assign push    = MemWrite && !Full;
  // Loads own the address port; a stalled load does not, so draining
  // continues and the hit eventually clears.
  assign pop     = !Empty && DM_Ready && !load_go;
  assign Stall   = (MemWrite && Full) || hit;

  assign DM_MemRead   = load_go;
  assign DM_MemWrite  = pop;
  assign DM_Addr      = load_go ? Addr : addr_q[head_q];
  assign DM_StoreType = st_q[head_q];
  assign DM_WD        = wd_q[head_q];
  assign DM_WPC       = wpc_q[head_q];

  always_comb begin
    head_d  = pop  ? head_q + AW'(1) : head_q;
    tail_d  = push ? tail_q + AW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        st_q[i]   <= '0;
        addr_q[i] <= '0;
        wd_q[i]   <= '0;
        wpc_q[i]  <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        st_q[tail_q]   <= StoreType;
        addr_q[tail_q] <= Addr;
        wd_q[tail_q]   <= WD;
        wpc_q[tail_q]  <= WPC;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        Clock;
  logic        Reset;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  StoreType;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic [31:0] WPC;
  logic        DM_Ready;
  logic        Stall;
  logic        DM_MemWrite;
  logic        DM_MemRead;
  logic [1:0]  DM_StoreType;
  logic [31:0] DM_Addr;
  logic [31:0] DM_WD;
  logic [31:0] DM_WPC;
  logic        Empty;
  logic        Full;

  store_buffer #(.DEPTH(4)) dut (
    .Clock(Clock), .Reset(Reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .StoreType(StoreType), .Addr(Addr), .WD(WD), .WPC(WPC),
    .DM_Ready(DM_Ready), .Stall(Stall), .DM_MemWrite(DM_MemWrite),
    .DM_MemRead(DM_MemRead), .DM_StoreType(DM_StoreType), .DM_Addr(DM_Addr),
    .DM_WD(DM_WD), .DM_WPC(DM_WPC), .Empty(Empty), .Full(Full)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] wpc;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every DM write must match the oldest issued store.
  always @(negedge Clock) begin
    if (Reset && DM_MemWrite) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h expected no write at %0t", DM_Addr, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", DM_Addr, e.addr);
        check("wr_data", DM_WD, e.wd);
        check("wr_type", {30'd0, DM_StoreType}, {30'd0, e.st});
        check("wr_pc",   DM_WPC, e.wpc);
      end
    end
  end

  task automatic idle();
    MemWrite = 1'b0; MemRead = 1'b0; StoreType = 2'd0;
    Addr = '0; WD = '0; WPC = '0;
  endtask

  task automatic cyc();
    @(posedge Clock); #1;
  endtask

  // Issue a store, hold it while stalled (bounded), push its expectation.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] t, input logic [31:0] pc);
    int unsigned n;
    MemWrite = 1'b1; MemRead = 1'b0; Addr = a; WD = d; StoreType = t; WPC = pc;
    exp_q.push_back({t, a, d, pc});
    n = 0;
    @(negedge Clock);
    while (Stall && n < 20) begin
      n++;
      @(negedge Clock);
    end
    if (n >= 20) check("store_stall_timeout", 32'd1, 32'd0);
    cyc();
    MemWrite = 1'b0;
  endtask

  task automatic wait_empty();
    int unsigned n;
    n = 0;
    while (!Empty && n < 20) begin
      n++;
      cyc();
    end
    check("drain_empty", {31'd0, Empty}, 32'd1);
  endtask

  initial begin
    Reset = 1'b0; DM_Ready = 1'b1;
    idle();
    #12;
    check("rst_empty", {31'd0, Empty}, 32'd1);
    check("rst_full", {31'd0, Full}, 32'd0);
    check("rst_dmw", {31'd0, DM_MemWrite}, 32'd0);
    check("rst_stall", {31'd0, Stall}, 32'd0);
    cyc();
    Reset = 1'b1;
    cyc();

    // Single word store, written the following cycle.
    MemWrite = 1'b1; Addr = 32'h0; WD = 32'h12345678; WPC = 32'h3000; StoreType = 2'd0;
    exp_q.push_back({2'd0, 32'h0, 32'h12345678, 32'h3000});
    @(negedge Clock);
    check("t1_stall", {31'd0, Stall}, 32'd0);
    cyc(); idle();
    @(negedge Clock);
    check("t1_dmw", {31'd0, DM_MemWrite}, 32'd1);
    check("t1_notempty", {31'd0, Empty}, 32'd0);
    cyc();
    check("t1_empty", {31'd0, Empty}, 32'd1);

    // Fill to Full, then a fifth store stalls until the first drain.
    DM_Ready = 1'b0;
    for (int i = 0; i < 4; i++)
      do_store(32'(i * 4), 32'hA0 + 32'(i), 2'd0, 32'h100 + 32'(i * 4));
    check("t2_full", {31'd0, Full}, 32'd1);
    MemWrite = 1'b1; Addr = 32'h10; WD = 32'hA4; WPC = 32'h110; StoreType = 2'd0;
    exp_q.push_back({2'd0, 32'h10, 32'hA4, 32'h110});
    @(negedge Clock);
    check("t2_stall_full", {31'd0, Stall}, 32'd1);
    cyc();
    DM_Ready = 1'b1;
    @(negedge Clock);
    check("t2_stall_popcycle", {31'd0, Stall}, 32'd1);
    check("t2_dmw_popcycle", {31'd0, DM_MemWrite}, 32'd1);
    cyc();
    @(negedge Clock);
    check("t2_accept", {31'd0, Stall}, 32'd0);
    cyc(); idle();
    wait_empty();

    // Load hitting a pending byte store stalls until it drains.
    DM_Ready = 1'b0;
    do_store(32'h3, 32'hdd, 2'd2, 32'h200);
    MemRead = 1'b1; Addr = 32'h0;
    @(negedge Clock);
    check("t3_stall", {31'd0, Stall}, 32'd1);
    check("t3_dmr", {31'd0, DM_MemRead}, 32'd0);
    check("t3_dmw", {31'd0, DM_MemWrite}, 32'd0);
    cyc();
    DM_Ready = 1'b1;
    @(negedge Clock);
    check("t3_stall_drain", {31'd0, Stall}, 32'd1);
    cyc();
    @(negedge Clock);
    check("t3_release", {31'd0, Stall}, 32'd0);
    check("t3_dmr_go", {31'd0, DM_MemRead}, 32'd1);
    check("t3_addr", DM_Addr, 32'h0);
    cyc(); idle();

    // Non-hitting load takes the port ahead of a pending store.
    do_store(32'h4, 32'h44, 2'd0, 32'h300);
    MemRead = 1'b1; Addr = 32'h8;
    @(negedge Clock);
    check("t4_stall", {31'd0, Stall}, 32'd0);
    check("t4_dmr", {31'd0, DM_MemRead}, 32'd1);
    check("t4_addr", DM_Addr, 32'h8);
    check("t4_dmw", {31'd0, DM_MemWrite}, 32'd0);
    cyc(); idle();
    @(negedge Clock);
    check("t4_drain_addr", DM_Addr, 32'h4);
    cyc();
    check("t4_empty", {31'd0, Empty}, 32'd1);

    // Simultaneous push and pop at count 2 keeps count at 2.
    DM_Ready = 1'b0;
    do_store(32'h20, 32'hB0, 2'd0, 32'h400);
    do_store(32'h24, 32'hB1, 2'd1, 32'h404);
    DM_Ready = 1'b1;
    do_store(32'h28, 32'hB2, 2'd0, 32'h408);
    DM_Ready = 1'b0;
    check("t5_notempty", {31'd0, Empty}, 32'd0);
    check("t5_notfull", {31'd0, Full}, 32'd0);
    do_store(32'h2C, 32'hB3, 2'd0, 32'h40C);
    check("t5_count3", {31'd0, Full}, 32'd0);
    do_store(32'h30, 32'hB4, 2'd0, 32'h410);
    check("t5_count4", {31'd0, Full}, 32'd1);
    DM_Ready = 1'b1;
    wait_empty();

    // Ten back-to-back stores wrap the pointers several times.
    for (int i = 0; i < 10; i++)
      do_store(32'h1000 + 32'(i * 4), 32'hC0DE0000 + 32'(i), 2'(i % 3), 32'h500 + 32'(i * 4));
    wait_empty();

    // Asynchronous reset with entries pending discards them.
    DM_Ready = 1'b0;
    for (int i = 0; i < 3; i++)
      do_store(32'h2000 + 32'(i * 4), 32'hDEAD0000 + 32'(i), 2'd0, 32'h600);
    #2;
    Reset = 1'b0;
    DM_Ready = 1'b1;
    #1;
    check("t6_empty", {31'd0, Empty}, 32'd1);
    check("t6_dmw", {31'd0, DM_MemWrite}, 32'd0);
    exp_q.delete();
    cyc();
    Reset = 1'b1;
    repeat (5) cyc();
    check("t6_still_empty", {31'd0, Empty}, 32'd1);

    check("leftover_expect", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
